// File: rtl/slap_spr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slap_spr_pkg
// Purpose  : Shared types and constants for the sprite scanline scheduler:
//            FSM state encoding, sprite-entry byte offsets, default sprite
//            height and the packed draw-job record.
// Revision : 1.0 - initial release
// ============================================================================
package slap_spr_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EVAL  = 3'd2,
    ISSUE = 3'd3,
    DONE  = 3'd4
  } spr_state_t;

  // Byte offsets within a 4-byte sprite entry
  localparam logic [1:0] OFS_HPOS = 2'd0;
  localparam logic [1:0] OFS_EXT  = 2'd1;
  localparam logic [1:0] OFS_VPOS = 2'd2;
  localparam logic [1:0] OFS_CODE = 2'd3;

  // Default sprite height in lines (power of two)
  localparam int SPR_H_DEFAULT = 16;

  // Draw job handed to the line-buffer engine
  typedef struct packed {
    logic [9:0] code;
    logic [3:0] row;
    logic [8:0] hpos;
    logic [3:0] col;
  } spr_job_t;

endpackage
`default_nettype wire

// File: rtl/spr_y_hit.sv
`default_nettype none
// ============================================================================
// Module   : spr_y_hit
// Purpose  : Vertical hit test for one sprite against the line being
//            prepared. diff wraps modulo 256 so sprites straddling line 0
//            still hit. Optional vertical flip of the row index when the
//            SPR_FLIP_EN macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spr_y_hit #(
  parameter int SPR_H = 16
) (
  input  logic [7:0] vline,
  input  logic [7:0] vpos,
  input  logic       flip,
  output logic       hit,
  output logic [3:0] row
);

  logic [7:0] w_diff;

  assign w_diff = vline - vpos;
  assign hit    = (w_diff < 8'(SPR_H));

`ifdef SPR_FLIP_EN
  assign row = flip ? (4'(SPR_H - 1) - w_diff[3:0]) : w_diff[3:0];
`else
  logic w_flip_unused;
  assign w_flip_unused = flip;
  assign row           = w_diff[3:0];
`endif

endmodule
`default_nettype wire

// File: rtl/sprite_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : sprite_scan_sched
// Purpose  : Per-scanline sprite evaluation scheduler. On each line_start it
//            walks sprite RAM (4 bytes/entry), tests each sprite against the
//            next line and hands one draw job per hit to the draw engine via
//            a valid/ready handshake. Also owns the ping-pong line-buffer
//            select. Optional screen flip via macro SPR_FLIP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_scan_sched
  import slap_spr_pkg::*;
#(
  parameter int NUM_SPRITES  = 512,
  parameter int MAX_PER_LINE = 32,
  parameter int SPR_H        = SPR_H_DEFAULT
) (
  input  logic        master_clk,
  input  logic        nRESET,
  input  logic        scan_en,
  input  logic        line_start,
  input  logic [7:0]  vline,
  input  logic        screen_flip,
  output logic [10:0] ram_addr,
  output logic        ram_rd,
  input  logic [7:0]  ram_data,
  output logic        job_valid,
  input  logic        job_ready,
  output logic [9:0]  job_code,
  output logic [3:0]  job_row,
  output logic [8:0]  job_hpos,
  output logic [3:0]  job_col,
  output logic        lbuf_sel,
  output logic        line_done,
  output logic        ovf,
  output logic [5:0]  spr_count
);

  localparam logic [8:0] C_LAST_PTR = 9'(NUM_SPRITES - 1);
  localparam logic [5:0] C_MAX      = 6'(MAX_PER_LINE);

  spr_state_t r_state, w_state_nxt;

  logic [8:0] r_ptr;
  logic [1:0] r_idx;
  logic       r_rd_pend;
  logic [1:0] r_rd_ofs;
  logic [7:0] r_vline;
  logic       r_flip;
  logic [8:0] r_hpos;
  logic [3:0] r_col;
  logic [9:0] r_code;
  logic [7:0] r_vpos;
  logic       r_lbuf;
  logic [5:0] r_count;
  logic       r_ovf;
  logic       r_done;

  logic       w_hit;
  logic [3:0] w_row;
  logic [8:0] w_hpos;
  logic       w_job_valid;
  logic       w_accept;
  logic       w_ptr_adv;
  logic       w_set_done;
  logic       w_set_ovf;
  logic       w_ext_unused;
  spr_job_t   w_job;

  assign w_ext_unused = ram_data[5];

  spr_y_hit #(
    .SPR_H (SPR_H)
  ) u_y_hit (
    .vline (r_vline),
    .vpos  (r_vpos),
    .flip  (r_flip),
    .hit   (w_hit),
    .row   (w_row)
  );

`ifdef SPR_FLIP_EN
  assign w_hpos = r_flip ? (9'h1F0 - r_hpos) : r_hpos;
`else
  assign w_hpos = r_hpos;
`endif

  assign w_job     = {r_code, w_row, w_hpos, r_col};
  assign job_code  = w_job.code;
  assign job_row   = w_job.row;
  assign job_hpos  = w_job.hpos;
  assign job_col   = w_job.col;
  assign job_valid = w_job_valid;
  assign ram_addr  = {r_ptr, r_idx};
  assign ram_rd    = (r_state == FETCH);
  assign lbuf_sel  = r_lbuf;
  assign line_done = r_done;
  assign ovf       = r_ovf;
  assign spr_count = r_count;

  // State register
  always_ff @(posedge master_clk) begin
    if (!nRESET) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode and per-cycle control strobes; line_start overrides all
  always_comb begin
    w_state_nxt = r_state;
    w_job_valid = 1'b0;
    w_accept    = 1'b0;
    w_ptr_adv   = 1'b0;
    w_set_done  = 1'b0;
    w_set_ovf   = 1'b0;
    case (r_state)
      IDLE: ;
      FETCH: begin
        if (scan_en && (r_idx == 2'd3)) w_state_nxt = EVAL;
      end
      EVAL: begin
        if (scan_en) begin
          if (!w_hit) begin
            w_ptr_adv = 1'b1;
            if (r_ptr == C_LAST_PTR) begin
              w_set_done  = 1'b1;
              w_state_nxt = DONE;
            end else begin
              w_state_nxt = FETCH;
            end
          end else if (r_count < C_MAX) begin
            w_state_nxt = ISSUE;
          end else begin
            w_set_ovf   = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      ISSUE: begin
        // Acceptance is not gated by scan_en so a presented job always drains
        w_job_valid = 1'b1;
        if (job_ready) begin
          w_accept  = 1'b1;
          w_ptr_adv = 1'b1;
          if (r_ptr == C_LAST_PTR) begin
            w_set_done  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = FETCH;
          end
        end
      end
      DONE: ;
      default: w_state_nxt = IDLE;
    endcase
    if (line_start) begin
      w_state_nxt = FETCH;
      w_job_valid = 1'b0;
      w_accept    = 1'b0;
      w_ptr_adv   = 1'b0;
      w_set_done  = 1'b0;
      w_set_ovf   = 1'b0;
    end
  end

  // Scan datapath: pointer, fetch sequencing, byte capture and line status
  always_ff @(posedge master_clk) begin
    if (!nRESET) begin
      r_ptr     <= 9'd0;
      r_idx     <= 2'd0;
      r_rd_pend <= 1'b0;
      r_rd_ofs  <= 2'd0;
      r_vline   <= 8'd0;
      r_flip    <= 1'b0;
      r_hpos    <= 9'd0;
      r_col     <= 4'd0;
      r_code    <= 10'd0;
      r_vpos    <= 8'd0;
      r_lbuf    <= 1'b0;
      r_count   <= 6'd0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else if (line_start) begin
      r_lbuf    <= ~r_lbuf;
      r_count   <= 6'd0;
      r_ovf     <= 1'b0;
      r_ptr     <= 9'd0;
      r_idx     <= 2'd0;
      r_rd_pend <= 1'b0;
      r_vline   <= vline;
      r_flip    <= screen_flip;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_set_done;
      if (w_set_ovf) r_ovf   <= 1'b1;
      if (w_accept)  r_count <= r_count + 6'd1;
      if (w_ptr_adv) r_ptr   <= r_ptr + 9'd1;
      if (scan_en) begin
        // Data for a read appears on the next enabled cycle
        r_rd_pend <= (r_state == FETCH);
        r_rd_ofs  <= r_idx;
        if (r_state == FETCH) r_idx <= r_idx + 2'd1;
        if (r_rd_pend) begin
          case (r_rd_ofs)
            OFS_HPOS: r_hpos[7:0] <= ram_data;
            OFS_EXT: begin
              r_hpos[8]   <= ram_data[0];
              r_col       <= ram_data[4:1];
              r_code[9:8] <= ram_data[7:6];
            end
            OFS_VPOS: r_vpos      <= ram_data;
            OFS_CODE: r_code[7:0] <= ram_data;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sprite_scan_sched.md
Name: sprite_scan_sched

Overview:
- Per-scanline sprite evaluation scheduler for the sprite layer.
- At each line start it walks sprite RAM, 4 bytes per sprite. For each sprite it tests vertical hit against the next line number.
- For every hit it issues one draw job (tile code, row, X position, colour) to the sprite draw/line-buffer engine through a valid/ready handshake.
- It also owns the ping-pong line-buffer select, replacing the PROM-driven sequencing.

Parameters:
- NUM_SPRITES, 512: sprite entries scanned per line. Entry n occupies RAM bytes 4n..4n+3.
- MAX_PER_LINE, 32: maximum jobs issued per line.
- SPR_H, 16: sprite height in lines; must be a power of two.

Ports:
- master_clk  in  1  system clock; all state changes on the rising edge.
- nRESET  in  1  synchronous, active-low reset.
- scan_en  in  1  clock enable for FSM advance and RAM reads.
- line_start  in  1  one-cycle strobe at start of horizontal blank. Sampled every cycle, regardless of scan_en.
- vline  in  8  line being prepared (next displayed line).
- screen_flip  in  1  flip request; used only with SPR_FLIP_EN.
- ram_addr  out  11  sprite RAM read address.
- ram_rd  out  1  read strobe; data returns on ram_data the next enabled cycle.
- ram_data  in  8  sprite RAM read data.
- job_valid  out  1  a job is presented.
- job_ready  in  1  the draw engine accepts the job.
- job_code  out  10  tile index.
- job_row  out  4  row within the sprite.
- job_hpos  out  9  X start.
- job_col  out  4  palette bank.
- lbuf_sel  out  1  line buffer being written; the other buffer is displayed.
- line_done  out  1  pulse when the scan completes before the next line_start.
- ovf  out  1  sticky per-line overflow flag.
- spr_count  out  6  jobs issued on the current line.

Behaviour:
- Reset values: all outputs 0; state IDLE; sprite pointer 0.
- Byte layout per entry:
  - +0 hpos[7:0]
  - +1 extra: bit0 hpos[8]; bits4:1 colour; bits7:6 code[9:8]
  - +2 vpos
  - +3 code[7:0]
- FSM states:
  - IDLE: wait for line_start.
  - FETCH: issue 4 consecutive reads of bytes +0..+3. Capture each byte one enabled cycle after its read.
  - EVAL: one cycle.
  - ISSUE: hold until the job is accepted.
  - DONE: wait for line_start.
- line_start in any state:
  - toggle lbuf_sel;
  - clear spr_count and ovf;
  - reset the pointer to 0;
  - latch vline;
  - go to FETCH next cycle.
  - If the previous scan was unfinished, it is aborted with no line_done pulse, and any pending job_valid drops the same cycle.
- Hit test: diff = (vline_latched - vpos) mod 256, computed in 8 bits. Hit iff diff < SPR_H; job_row = diff[3:0].
  - Wrap-around is intended: vpos=250, vline=4 gives diff=10, a hit.
- EVAL outcomes:
  - Miss: advance the pointer and return to FETCH.
  - Hit with spr_count < MAX_PER_LINE: go to ISSUE.
  - Hit with spr_count = MAX_PER_LINE: set ovf and go to DONE.
- ISSUE:
  - job_valid=1; all job fields stay stable while job_valid is high and job_ready is low.
  - On valid&ready: spr_count increments; the pointer advances.
  - Next state is FETCH, or DONE if the pointer wrapped past NUM_SPRITES-1.
  - job_valid may fall only after acceptance or on line_start.
- Last sprite processed (pointer = NUM_SPRITES-1, miss or accepted): line_done=1 for one cycle and enter DONE.
- scan_en=0 freezes the FSM, ram_rd and the pointer. Handshake acceptance still completes while job_valid is high.
- Latency: a miss costs 5 enabled cycles. A hit costs 5 cycles plus the ready wait, with a minimum of 6.
- Reset asserted mid-scan overrides line_start and returns everything to the reset values.

Optional Feature:
- Macro: SPR_FLIP_EN.
- Defined, with screen_flip=1 latched at line_start:
  - job_row = SPR_H-1-diff[3:0];
  - job_hpos = 9'h1F0 - hpos, using 9-bit wrap.
- Undefined: screen_flip is ignored and the fields pass through unmodified.

Decomposition:
- Package slap_spr_pkg holds:
  - state enum (IDLE, FETCH, EVAL, ISSUE, DONE);
  - byte-offset constants (OFS_HPOS=0, OFS_EXT=1, OFS_VPOS=2, OFS_CODE=3);
  - SPR_H default;
  - packed job struct {code, row, hpos, col}.
- One sub-module, spr_y_hit: combinational diff, hit and row (with flip), instantiated once.

Test Plan:
- Sprite 0 = {hpos=0x34, ext=0xC7, vpos=0x20, code=0x5A}, all others vpos=0x80, vline=0x25, job_ready=1 → one job: code=0x35A, row=5, hpos=0x134, col=3. spr_count=1, line_done pulses, lbuf_sel toggled.
- vpos=250, vline=4 → hit with row=10. vpos=0x10, vline=0x20 → no job.
- 40 sprites all hitting, job_ready=1 → exactly 32 jobs, ovf=1, no line_done.
- job_ready held low for 7 cycles on the first hit → job fields constant and job_valid continuously high. Accepted on cycle 8; spr_count=1 only after acceptance.
- line_start asserted mid-scan while job_valid=1 → job_valid drops the same cycle, lbuf_sel toggles, ram_addr restarts at 0, no line_done.
- With SPR_FLIP_EN, screen_flip=1, case 1 stimulus → row=10, hpos=0x0BC.
